// File: rtl/spi_responder.sv
// SPI slave (CPOL=0, CPHA=0, MSB first) giving an external master 16-bit frame access to an
// external register bank: {R/W, addr[6:0]} then 8 data bits; ID_BYTE is returned during the address byte.
module spi_responder #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter logic [7:0]  ID_BYTE     = 8'hA5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_strobe,
  input  logic [7:0]            i_rd_data,
  output logic                  o_wr_strobe,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [7:0]            o_wr_data,
  output logic                  o_frame_error,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT_CS} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_prev, cs_prev;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall;
  logic [4:0] bit_cnt;
  logic [14:0] rx;
  logic [15:0] rx_next;
  logic [7:0] tx;
  logic       start, abort, addr_done, data_done;

  // CS synchroniser resets low so a master already holding CS low at reset release
  // cannot produce a false falling edge; it must cycle CS first.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign rx_next   = {rx, mosi_s};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    abort      = 1'b0;
    addr_done  = 1'b0;
    data_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && i_enable) begin
          start      = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (cs_s) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise && bit_cnt == 5'd7) begin
          addr_done  = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (cs_s) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise && bit_cnt == 5'd15) begin
          data_done  = 1'b1;
          state_next = WAIT_CS;
        end
      end
      WAIT_CS: begin
        if (cs_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy    = (state != IDLE);
  assign o_miso_oe = (state != IDLE);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_miso        <= 1'b0;
      o_rd_addr     <= '0;
      o_rd_strobe   <= 1'b0;
      o_wr_strobe   <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_frame_error <= 1'b0;
      bit_cnt       <= '0;
      rx            <= '0;
      tx            <= '0;
    end else begin
      o_rd_strobe   <= 1'b0;
      o_wr_strobe   <= 1'b0;
      o_frame_error <= 1'b0;

      if (o_rd_strobe) tx <= i_rd_data;

      if (start) begin
        tx      <= ID_BYTE;
        o_miso  <= ID_BYTE[7];
        bit_cnt <= '0;
      end

      if (abort) begin
        o_miso        <= 1'b0;
        o_frame_error <= 1'b1;
      end else if (state == ADDR || state == DATA) begin
        if (sclk_rise) begin
          rx      <= rx_next[14:0];
          bit_cnt <= bit_cnt + 5'd1;
        end
        // The 8th fall presents the freshly loaded data byte's MSB without shifting.
        if (sclk_fall) begin
          if (bit_cnt == 5'd8) begin
            o_miso <= tx[7];
          end else begin
            o_miso <= tx[6];
            tx     <= {tx[6:0], 1'b0};
          end
        end
      end

      if (addr_done) begin
        if (rx_next[7]) begin
          o_rd_addr   <= rx_next[ADDR_WIDTH-1:0];
          o_rd_strobe <= 1'b1;
        end else begin
          tx <= '0;
        end
      end

      if (data_done) begin
        o_miso <= 1'b0;
        if (!rx_next[15]) begin
          o_wr_addr   <= rx_next[8 +: ADDR_WIDTH];
          o_wr_data   <= rx_next[7:0];
          o_wr_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Randomised and directed SPI master frames against spi_responder, compared with a
// frame-level model of what the master should receive and which strobes should fire.
module tb_spi_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe;
  logic [6:0] rd_addr, wr_addr;
  logic       rd_strobe, wr_strobe, frame_error, busy;
  logic [7:0] rd_data, wr_data;
  logic [7:0] mem [128];

  always #10 clk = ~clk;

  assign rd_data = mem[rd_addr];

  spi_responder #(.ADDR_WIDTH(7), .ID_BYTE(8'hA5), .SYNC_STAGES(2)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable),
    .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe),
    .o_rd_addr(rd_addr), .o_rd_strobe(rd_strobe), .i_rd_data(rd_data),
    .o_wr_strobe(wr_strobe), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_frame_error(frame_error), .o_busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: running totals plus the most recent payloads.
  int         wr_total = 0, rd_total = 0, err_total = 0;
  logic [6:0] last_wa, last_ra;
  logic [7:0] last_wd;
  longint     last_wr_time;
  longint     rise16_time;

  always @(negedge clk) begin
    if (wr_strobe) begin
      wr_total++;
      last_wa      = wr_addr;
      last_wd      = wr_data;
      last_wr_time = $time;
    end
    if (rd_strobe) begin
      rd_total++;
      last_ra = rd_addr;
    end
    if (frame_error) err_total++;
  end

  int half_ns = 100;

  // ev_kind: 0 none, 1 reset after fall of bit ev_bit, 2 enable on, 3 enable off
  task automatic run_frame(input logic [15:0] word, input int nbits, input int ev_bit, input int ev_kind);
    int          wr0, rd0, er0, nrx, k;
    bit          en0, acc, full, stop;
    logic [31:0] rxbits, exp_full, first, extra, mask;
    wr0 = wr_total; rd0 = rd_total; er0 = err_total;
    en0 = enable; stop = 0; nrx = 0; rxbits = '0;
    @(negedge clk);
    cs_n = 1'b0;
    mosi = word[15];
    #(half_ns);
    for (int i = 0; i < nbits; i++) begin
      rxbits = {rxbits[30:0], miso};
      check("oe_in_frame", {31'b0, miso_oe}, {31'b0, en0});
      sclk = 1'b1;
      nrx++;
      if (i == 15) rise16_time = $time;
      #(half_ns);
      sclk = 1'b0;
      mosi = (i + 1 < 16) ? word[14-i] : 1'($urandom);
      if (ev_kind != 0 && i + 1 == ev_bit) begin
        if (ev_kind == 1) begin
          rst_n = 1'b0;
          #1;
          check("rst_ctl", {26'b0, miso, miso_oe, busy, rd_strobe, wr_strobe, frame_error}, 32'd0);
          check("rst_addr", {18'b0, rd_addr, wr_addr}, 32'd0);
          check("rst_wdata", {24'b0, wr_data}, 32'd0);
          #59;
          rst_n = 1'b1;
          stop = 1;
        end else if (ev_kind == 2) begin
          enable = 1'b1;
        end else begin
          enable = 1'b0;
        end
      end
      #(half_ns);
      if (stop) break;
    end
    cs_n = 1'b1;
    repeat (12) @(negedge clk);

    acc  = en0 && (ev_kind != 1);
    full = acc && (nbits >= 16);
    exp_full = en0 ? {16'h0, 8'hA5, (word[15] ? mem[word[14:8]] : 8'h00)} : 32'h0;
    k     = (nrx < 16) ? nrx : 16;
    first = rxbits >> (nrx - k);
    mask  = (32'd1 << (nrx - k)) - 32'd1;
    extra = rxbits & mask;
    check("miso_bits", first, exp_full >> (16 - k));
    check("miso_after16", extra, 32'd0);

    check("wr_count", wr_total - wr0, (full && !word[15]) ? 1 : 0);
    if (full && !word[15]) begin
      check("wr_addr", {25'b0, last_wa}, {25'b0, word[14:8]});
      check("wr_data", {24'b0, last_wd}, {24'b0, word[7:0]});
      check("wr_latency", 32'(last_wr_time - rise16_time), 32'd60);
    end
    check("rd_count", rd_total - rd0, (en0 && word[15] && nrx >= 8) ? 1 : 0);
    if (en0 && word[15] && nrx >= 8)
      check("rd_addr", {25'b0, last_ra}, {25'b0, word[14:8]});
    check("frame_err", err_total - er0, (acc && nbits < 16) ? 1 : 0);
    check("idle_after", {30'b0, busy, miso_oe}, 32'd0);
  endtask

  initial begin
    int r, nb, evk, evb;
    rst_n = 1'b0; enable = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
    repeat (5) @(negedge clk);
    check("reset_ctl", {26'b0, miso, miso_oe, busy, rd_strobe, wr_strobe, frame_error}, 32'd0);
    check("reset_addr", {18'b0, rd_addr, wr_addr}, 32'd0);
    check("reset_wdata", {24'b0, wr_data}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run_frame(16'h123C, 16, 0, 0);
    mem[5] = 8'h5A;
    run_frame(16'h8500, 16, 0, 0);
    run_frame(16'h20FF, 11, 0, 0);
    run_frame(16'h2101, 16, 0, 0);
    run_frame(16'h0780, 20, 0, 0);
    enable = 1'b0;
    run_frame(16'h3344, 16, 0, 0);
    run_frame(16'h3355, 16, 8, 2);
    run_frame(16'h3366, 16, 0, 0);
    run_frame(16'h4477, 16, 4, 3);
    enable = 1'b1;
    run_frame(16'h2AC3, 16, 9, 1);
    run_frame(16'h2BC4, 16, 0, 0);

    for (int n = 0; n < 24; n++) begin
      half_ns = 20 * $urandom_range(5, 8);
      r   = $urandom_range(0, 9);
      nb  = (r < 6) ? 16 : (r < 8) ? $urandom_range(17, 20) : $urandom_range(1, 15);
      evk = ($urandom_range(0, 5) == 0) ? 3 : 0;
      evb = $urandom_range(1, 12);
      if (evb > nb) evk = 0;
      run_frame(16'($urandom), nb, evb, evk);
      enable = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI slave, the far end of the HDP-1280-2 style 16-bit SPI master: CPOL=0, CPHA=0, MSB first, active-low CS.
- Lets an external SPI master (host MCU, or our own master in loopback) read and write FPGA-side control registers.
- Frame format: upper byte = {R/W, 7-bit address}, with R/W=1 for read and 0 for write; lower byte = write data (MOSI) or read data (MISO).
- Sits between the board SPI pins and the register bank. Register storage is external to this block.

Parameters:
- ADDR_WIDTH, 7, address bits taken from upper byte [6:0].
- ID_BYTE, 8'hA5, byte shifted out on MISO during the upper byte of every frame.
- SYNC_STAGES, 2, synchroniser flops on SCLK/CS/MOSI (min 2).

Ports:
- i_clock  in  1  system clock (50 MHz). Sole clock; SCLK is sampled as data.
- i_reset_n  in  1  asynchronous active-low reset.
- i_enable  in  1  when low: frames ignored, MISO output disabled, no strobes.
- i_sclk  in  1  SPI clock from master (async).
- i_cs_n  in  1  SPI chip select, active low (async).
- i_mosi  in  1  SPI data in (async).
- o_miso  out  1  SPI data out.
- o_miso_oe  out  1  MISO output enable; high only while a frame is in progress.
- o_rd_addr  out  ADDR_WIDTH  read address presented to register bank.
- o_rd_strobe  out  1  one-cycle pulse when o_rd_addr becomes valid for a read.
- i_rd_data  in  8  register bank data; sampled exactly 1 i_clock after o_rd_strobe.
- o_wr_strobe  out  1  one-cycle write pulse.
- o_wr_addr  out  ADDR_WIDTH  write address, valid with o_wr_strobe.
- o_wr_data  out  8  write data, valid with o_wr_strobe.
- o_frame_error  out  1  one-cycle pulse: CS deasserted mid-frame.
- o_busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: o_miso=0, o_miso_oe=0, o_rd_addr=0, o_wr_addr=0, o_wr_data=0; all strobes 0; o_busy=0; state=IDLE; bit counter=0.
- Synchronisation: SCLK, CS_n and MOSI each pass through SYNC_STAGES flops. Edges are detected on the synchronised SCLK (current vs previous). i_clock must be ≥8× SCLK.
- MOSI is sampled on a detected SCLK rise. MISO is updated on a detected SCLK fall.
- States:
  - IDLE: waits for synchronised CS_n falling edge with i_enable=1. On entry to ADDR: load tx shift reg with ID_BYTE, drive o_miso=ID_BYTE[7], o_miso_oe=1, o_busy=1, bit counter=0.
  - ADDR: each rise shifts MOSI into the rx shift reg and increments the counter; each fall shifts the next tx bit out. On the 8th rise: latch R/W and address.
    - Read: o_rd_addr=address, pulse o_rd_strobe; the next cycle loads i_rd_data into the tx shift reg.
    - Write: tx shift reg is loaded with 8'h00.
    - Move to DATA.
  - DATA: the 8th fall (the end of the address byte) drives tx[7]. Then shift on each fall, sample on each rise. On the 16th rise: if write, o_wr_addr/o_wr_data update and o_wr_strobe pulses one cycle. Go to WAIT_CS.
  - WAIT_CS: further SCLK edges are ignored; o_miso holds 0. When CS_n rises: o_miso_oe=0, o_busy=0, return to IDLE.
- Abort: CS_n rises in ADDR or DATA (counter < 16) → pulse o_frame_error, no o_wr_strobe, return to IDLE. o_rd_strobe already issued is not retracted.
- Frames longer than 16 bits: extra bits are ignored and only the first 16 count. Back-to-back frames need CS_n high for ≥1 synchronised sample.
- i_enable deasserted mid-frame: the current frame completes normally; new frames are blocked.
- An asynchronous reset mid-frame returns immediately to IDLE with reset values. The frame in flight is discarded, and the master's CS must cycle before the next frame is accepted.
- Latency: o_wr_strobe fires SYNC_STAGES+1 i_clock cycles after the 16th SCLK rise at the pins.

Test Plan:
- Write frame 16'h12_3C → single o_wr_strobe with o_wr_addr=7'h12, o_wr_data=8'h3C; o_rd_strobe never asserted; MISO upper byte reads 8'hA5.
- Read frame 16'h85_00 with bank returning 8'h5A for addr 7'h05 → o_rd_strobe once with o_rd_addr=7'h05; master receives 16'hA5_5A; no o_wr_strobe.
- CS_n raised after 11 SCLK rises of write 16'h20_FF → o_frame_error pulse, no o_wr_strobe, o_busy=0, o_miso_oe=0; following write 16'h21_01 completes normally.
- 20 SCLK pulses in one write frame 16'h07_80 → exactly one o_wr_strobe (addr 7'h07, data 8'h80); extra clocks ignored; MISO=0 after bit 16.
- i_enable=0 with a full write frame → no strobes, o_miso_oe stays 0; assert i_enable mid-way through a second frame → that frame ignored, third frame accepted.
- i_reset_n pulled low at bit 9 of a write → all outputs return to reset values immediately; no o_wr_strobe; next full frame after CS cycles is accepted.
